// File: rtl/mux_n_to_1_scan.sv
// Registered N-channel multiplexer with manual select, auto-scan and hold.
// The next state is decoded from hold/mode each cycle, and it picks which
// update rule applies on that same edge. Outputs and state share one register stage.
module mux_n_to_1_scan #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DWELL  = 50_000_000,
    localparam int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH*DATA_W-1:0]   din,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     mode,
    input  logic                     hold,
    output logic [DATA_W-1:0]        y,
    output logic [SEL_W-1:0]         cur_sel,
    output logic                     step,
    output logic                     range_err,
    output logic                     scan_act
);

    localparam int unsigned CNT_W = $clog2(DWELL + 1);

    localparam logic [1:0] MAN  = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [CNT_W-1:0]  cnt_base;
    logic [SEL_W-1:0]  sel_next;
    logic [SEL_W-1:0]  scan_base;
    logic [SEL_W-1:0]  scan_wrap;
    logic [DATA_W-1:0] y_next;
    logic              step_next;
    logic              range_err_next;

    // Channel lookup; an index with no matching channel yields zero.
    function automatic logic [DATA_W-1:0] pick(input logic [N_CH*DATA_W-1:0] d,
                                               input logic [SEL_W-1:0] idx);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (idx == SEL_W'(k)) begin
                r = d[k*DATA_W +: DATA_W];
            end
        end
        return r;
    endfunction

    // True when the index names a real channel (N_CH need not be a power of two).
    function automatic logic in_range(input logic [SEL_W-1:0] idx);
        return ({1'b0, idx} < (SEL_W + 1)'(N_CH));
    endfunction

    // Next-state decode plus the next value of every registered output.
    always_comb begin
        next_state     = MAN;
        y_next         = y;
        sel_next       = cur_sel;
        cnt_next       = cnt;
        step_next      = 1'b0;
        range_err_next = range_err;

        // A scan entered from MAN starts its dwell afresh; one resumed from HOLD keeps its count.
        cnt_base  = (state == MAN) ? '0 : cnt;
        // An out-of-range manual index left in cur_sel restarts the scan at channel 0.
        scan_base = in_range(cur_sel) ? cur_sel : '0;
        scan_wrap = (scan_base == SEL_W'(N_CH - 1)) ? '0 : scan_base + SEL_W'(1);

        if (hold) begin
            next_state = HOLD;
        end else if (mode) begin
            next_state = SCAN;
        end

        case (next_state)
            MAN: begin
                sel_next       = sel;
                y_next         = pick(din, sel);
                range_err_next = ~in_range(sel);
                cnt_next       = '0;
            end
            SCAN: begin
                range_err_next = 1'b0;
                if (cnt_base == CNT_W'(DWELL - 1)) begin
                    cnt_next  = '0;
                    sel_next  = scan_wrap;
                    step_next = 1'b1;
                end else begin
                    cnt_next  = cnt_base + CNT_W'(1);
                    sel_next  = scan_base;
                end
                y_next = pick(din, sel_next);
            end
            default: begin
                // HOLD: everything frozen, step stays low
            end
        endcase
    end

    // State and output registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MAN;
            y         <= '0;
            cur_sel   <= '0;
            cnt       <= '0;
            step      <= 1'b0;
            range_err <= 1'b0;
            scan_act  <= 1'b0;
        end else begin
            state     <= next_state;
            y         <= y_next;
            cur_sel   <= sel_next;
            cnt       <= cnt_next;
            step      <= step_next;
            range_err <= range_err_next;
            scan_act  <= (next_state == SCAN);
        end
    end

endmodule

// File: tb/tb_mux_n_to_1_scan.sv
// Bench for mux_n_to_1_scan: a 4-channel unit (main) and a 5-channel unit
// (non-power-of-two range handling). Stimulus pushes expected outputs for the
// next edge into a queue; a negedge monitor pops and compares them.
module tb_mux_n_to_1_scan;

    localparam int unsigned DW    = 4;
    localparam int unsigned DWELL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        hold;
    logic [15:0] din_a;
    logic [1:0]  sel_a;
    logic [19:0] din_b;
    logic [2:0]  sel_b;

    logic [3:0]  y_a,  y_b;
    logic [1:0]  cs_a;
    logic [2:0]  cs_b;
    logic        step_a, step_b, rerr_a, rerr_b, sact_a, sact_b;

    mux_n_to_1_scan #(.N_CH(4), .DATA_W(DW), .DWELL(DWELL)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .sel(sel_a), .mode(mode), .hold(hold),
        .y(y_a), .cur_sel(cs_a), .step(step_a), .range_err(rerr_a), .scan_act(sact_a)
    );

    mux_n_to_1_scan #(.N_CH(5), .DATA_W(DW), .DWELL(DWELL)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .sel(sel_b), .mode(mode), .hold(hold),
        .y(y_b), .cur_sel(cs_b), .step(step_b), .range_err(rerr_b), .scan_act(sact_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          unit_id;
        logic [95:0] name;
        logic [3:0]  y;
        logic [2:0]  cs;
        logic        step;
        logic        rerr;
        logic        sact;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Queue the outputs expected right after the next rising edge.
    task automatic expect_nx(input int unit_id, input logic [95:0] name, input logic [3:0] y,
                             input logic [2:0] cs, input logic step, input logic rerr,
                             input logic sact);
        exp_t e;
        e.due = cyc + 1; e.unit_id = unit_id; e.name = name;
        e.y = y; e.cs = cs; e.step = step; e.rerr = rerr; e.sact = sact;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every entry due at this cycle; an overdue entry is a failure.
    always @(negedge clk) begin
        exp_t e;
        logic [3:0] ay;
        logic [2:0] acs;
        logic       ast, are, asa;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.unit_id == 0) begin
                ay = y_a; acs = {1'b0, cs_a}; ast = step_a; are = rerr_a; asa = sact_a;
            end else begin
                ay = y_b; acs = cs_b; ast = step_b; are = rerr_b; asa = sact_b;
            end
            n_tests++;
            if (e.due != cyc ||
                {ay, acs, ast, are, asa} !== {e.y, e.cs, e.step, e.rerr, e.sact}) begin
                n_fail++;
                $display("FAIL %0s unit=%0d cyc=%0d: got y=%h cs=%0d step=%b rerr=%b sact=%b, want y=%h cs=%0d step=%b rerr=%b sact=%b",
                         e.name, e.unit_id, cyc, ay, acs, ast, are, asa,
                         e.y, e.cs, e.step, e.rerr, e.sact);
            end
        end
    end

    // Reference state for the 4-channel unit in the scan/hold/reset sections.
    int         m_cnt;
    logic [1:0] m_cs;
    logic [3:0] m_y;

    function automatic logic [3:0] ch_a(input logic [1:0] k);
        return din_a[int'(k)*4 +: 4];
    endfunction

    task automatic model_edge(input logic [95:0] name);
        logic st, sa;
        st = 1'b0;
        sa = 1'b0;
        if (rst) begin
            m_cnt = 0; m_cs = 2'd0; m_y = 4'h0;
        end else if (hold) begin
            // frozen
        end else if (!mode) begin
            m_cs = sel_a; m_y = ch_a(sel_a); m_cnt = 0;
        end else begin
            if (m_cnt == int'(DWELL) - 1) begin
                m_cnt = 0;
                m_cs  = (m_cs == 2'd3) ? 2'd0 : m_cs + 2'd1;
                st    = 1'b1;
            end else begin
                m_cnt++;
            end
            m_y = ch_a(m_cs);
            sa  = 1'b1;
        end
        expect_nx(0, name, m_y, {1'b0, m_cs}, st, 1'b0, sa);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mode = 1'b0; hold = 1'b0;
        din_a = 16'hFFFF; sel_a = 2'd0;
        din_b = 20'h74321; sel_b = 3'd0;

        // Reset held two clocks with all-ones data
        expect_nx(0, "reset1", 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        expect_nx(1, "reset1_b", 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_nx(0, "reset2", 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();

        // Release into manual, sel=2, channel 2 = A
        rst = 1'b0; sel_a = 2'd2; din_a = 16'h0A00;
        expect_nx(0, "rel_sel2", 4'hA, 3'd2, 1'b0, 1'b0, 1'b0);
        tick();

        // Manual select sweep
        din_a = 16'h4321;
        for (int s = 0; s < 4; s++) begin
            sel_a = 2'(s);
            expect_nx(0, "man_sel", 4'(s + 1), 3'(s), 1'b0, 1'b0, 1'b0);
            tick();
        end
        din_a = 16'h9321;
        expect_nx(0, "man_live", 4'h9, 3'd3, 1'b0, 1'b0, 1'b0);
        tick();

        // Range handling on the 5-channel unit
        sel_b = 3'd6;
        expect_nx(1, "rng_sel6", 4'h0, 3'd6, 1'b0, 1'b1, 1'b0);
        tick();
        sel_b = 3'd4;
        expect_nx(1, "rng_sel4", 4'h7, 3'd4, 1'b0, 1'b0, 1'b0);
        tick();
        sel_b = 3'd1;
        expect_nx(1, "rng_sel1", 4'h2, 3'd1, 1'b0, 1'b0, 1'b0);
        tick();

        // Back to channel 0 in manual before scanning
        sel_a = 2'd0; din_a = 16'h4321;
        expect_nx(0, "man_sel0", 4'h1, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        m_cnt = 0; m_cs = 2'd0; m_y = 4'h1;

        // Auto-scan: 18 edges leaves cur_sel=0, cnt=2; channel 2 data changes mid-run
        mode = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (i == 9) din_a = 16'h4B21;
            model_edge("scan");
        end

        // Hold for 10 clocks at cnt=2, then release
        hold = 1'b1;
        for (int i = 0; i < 10; i++) model_edge("hold");
        hold = 1'b0;
        model_edge("hold_rel1");
        model_edge("hold_rel2");

        // Advance to cur_sel=2, cnt=1, then reset mid-scan
        for (int i = 0; i < 5; i++) model_edge("scan2");
        rst = 1'b1;
        model_edge("rst_mid");
        rst = 1'b0;
        for (int i = 0; i < 8; i++) model_edge("rescan");

        for (int i = 0; i < 5 && sb.size() > 0; i++) tick();
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
